// File: rtl/load_writeback_unit.sv
// Load path from the data-memory read port to the register-file write port (A3/WD3/WE3).
// Define LOAD_TIMEOUT_EN to abandon a load whose read data never returns.
module load_writeback_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        WE3,
    output logic        busy,
    output logic        ld_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t      state_r;
    logic [1:0]  lane_r;
    logic [4:0]  rd_r;
    logic [2:0]  funct3_r;
    logic        accept_s;
    logic        req_err_s;
    logic        timeout_s;
    logic [31:0] ext_data_s;

    function automatic logic load_illegal(input logic [2:0] f3, input logic [1:0] lane);
        logic bad;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = lane[0];
            3'b010:         bad = (lane != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    assign accept_s   = ld_valid && ld_ready;
    assign req_err_s  = load_illegal(ld_funct3, ld_addr[1:0]);
    assign ext_data_s = extract_load(funct3_r, lane_r, mem_rdata);

`ifdef LOAD_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_r;

    // Counts REQ cycles without read data; held at zero outside REQ so each load starts fresh.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_REQ && !mem_rvalid) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Terminal count is reached in the TIMEOUT_CYCLES-th REQ cycle; rvalid in that cycle still wins.
    assign timeout_s = (state_r == ST_REQ) && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Load sequencing FSM with all handshake and write-port outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            lane_r   <= 2'b00;
            rd_r     <= 5'd0;
            funct3_r <= 3'b000;
            ld_ready <= 1'b1;
            busy     <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0000_0000;
            A3       <= 5'd0;
            WD3      <= 32'h0000_0000;
            WE3      <= 1'b0;
            ld_err   <= 1'b0;
        end else begin
            ld_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    WE3 <= 1'b0;
                    A3  <= 5'd0;
                    WD3 <= 32'h0000_0000;
                    if (accept_s) begin
                        lane_r   <= ld_addr[1:0];
                        rd_r     <= ld_rd;
                        funct3_r <= ld_funct3;
                        if (req_err_s) begin
                            ld_err <= 1'b1;
                        end else begin
                            state_r  <= ST_REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= {ld_addr[31:2], 2'b00};
                            ld_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_rvalid) begin
                        state_r <= ST_WB;
                        mem_req <= 1'b0;
                        // Writes to x0 still pass through WB but never touch the register file.
                        WE3     <= (rd_r != 5'd0);
                        A3      <= rd_r;
                        WD3     <= (rd_r != 5'd0) ? ext_data_s : 32'h0000_0000;
                    end else if (timeout_s) begin
                        state_r  <= ST_IDLE;
                        mem_req  <= 1'b0;
                        ld_ready <= 1'b1;
                        busy     <= 1'b0;
                        ld_err   <= 1'b1;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WB: begin
                    state_r  <= ST_IDLE;
                    WE3      <= 1'b0;
                    A3       <= 5'd0;
                    WD3      <= 32'h0000_0000;
                    ld_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    mem_req  <= 1'b0;
                    WE3      <= 1'b0;
                    A3       <= 5'd0;
                    WD3      <= 32'h0000_0000;
                    ld_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Randomized and directed bench for load_writeback_unit against an arithmetic reference model.
module tb_load_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic        busy;
    logic        ld_err;

    int n_checks = 0;
    int n_fail   = 0;

    load_writeback_unit dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_rd(ld_rd), .ld_funct3(ld_funct3),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .A3(A3), .WD3(WD3), .WE3(WE3), .busy(busy), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_err(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if ((f3 == 3'b001 || f3 == 3'b101) && (addr % 2) != 0) return 1'b1;
        if (f3 == 3'b010 && (addr % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] data);
        longint v;
        int unsigned bi = addr % 4;
        int unsigned hi = (addr % 4) / 2;
        case (f3)
            3'b000: begin v = (data >> (8 * bi)) % 256;    if (v > 127)   v -= 256;   end
            3'b100: v = (data >> (8 * bi)) % 256;
            3'b001: begin v = (data >> (16 * hi)) % 65536; if (v > 32767) v -= 65536; end
            3'b101: v = (data >> (16 * hi)) % 65536;
            3'b010: v = data;
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    // Called just after a falling edge with the unit idle; returns just after a falling edge, idle.
    task automatic do_load(input logic [31:0] addr, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] rdata, input int wait_n);
        bit          err = model_err(f3, addr);
        logic [31:0] exp = model_wd(f3, addr, rdata);
        check_eq("ready_pre", ld_ready, 1);
        ld_valid = 1'b1; ld_addr = addr; ld_rd = rd; ld_funct3 = f3;
        @(posedge clk); #1;
        ld_valid = 1'b0; ld_addr = $urandom; ld_rd = 5'($urandom); ld_funct3 = 3'($urandom);
        if (err) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            check_eq("err_pulse", ld_err, 1);
            check_eq("err_memreq", mem_req, 0);
            check_eq("err_ready", ld_ready, 1);
            check_eq("err_we", WE3, 0);
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            @(negedge clk);
            check_eq("err_pulse_end", ld_err, 0);
            check_eq("err_we2", WE3, 0);
            check_eq("err_memreq2", mem_req, 0);
        end else begin
            for (int k = 0; k <= wait_n; k++) begin
                mem_rvalid = (k == wait_n);
                mem_rdata  = (k == wait_n) ? rdata : $urandom;
                @(negedge clk);
                check_eq("req_memreq", mem_req, 1);
                check_eq("req_addr", mem_addr, {addr[31:2], 2'b00});
                check_eq("req_busy", busy, 1);
                check_eq("req_ready", ld_ready, 0);
                check_eq("req_we", WE3, 0);
                check_eq("req_err", ld_err, 0);
                @(posedge clk); #1;
            end
            mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            @(negedge clk);
            check_eq("wb_we", WE3, (rd != 0) ? 1 : 0);
            check_eq("wb_a3", A3, (rd != 0) ? rd : 0);
            check_eq("wb_wd", WD3, (rd != 0) ? exp : 0);
            check_eq("wb_memreq", mem_req, 0);
            check_eq("wb_busy", busy, 1);
            check_eq("wb_err", ld_err, 0);
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            @(negedge clk);
            check_eq("post_we", WE3, 0);
            check_eq("post_wd", WD3, 0);
            check_eq("post_busy", busy, 0);
            check_eq("post_ready", ld_ready, 1);
        end
    endtask

    initial begin
        rst = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_rd = '0; ld_funct3 = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        #12;
        check_eq("rst_ready", ld_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_memreq", mem_req, 0);
        check_eq("rst_we", WE3, 0);
        check_eq("rst_wd", WD3, 0);
        check_eq("rst_err", ld_err, 0);
        #10 rst = 1'b1;
        @(negedge clk);

        do_load(32'h0000_2004, 5'd9, 3'b010, 32'hDEAD_BEEF, 2);
        do_load(32'h0000_1003, 5'd5, 3'b000, 32'h80FF_0000, 0);
        do_load(32'h0000_1003, 5'd5, 3'b100, 32'h80FF_0000, 1);
        do_load(32'h0000_1002, 5'd5, 3'b001, 32'h80FF_0000, 0);
        do_load(32'h0000_1001, 5'd5, 3'b001, 32'h80FF_0000, 0);
        do_load(32'h0000_1000, 5'd5, 3'b011, 32'h80FF_0000, 0);
        do_load(32'h0000_1000, 5'd0, 3'b010, 32'h1234_5678, 0);
        do_load(32'h0000_1006, 5'd31, 3'b101, 32'hF00D_8001, 0);

        // Asynchronous reset in the middle of a REQ phase.
        ld_valid = 1'b1; ld_addr = 32'h0000_3000; ld_rd = 5'd7; ld_funct3 = 3'b010;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_memreq", mem_req, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_memreq", mem_req, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_ready", ld_ready, 1);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        repeat (2) begin
            @(negedge clk);
            check_eq("arst_we", WE3, 0);
        end
        #2 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("rel_we", WE3, 0);
            check_eq("rel_ready", ld_ready, 1);
            check_eq("rel_memreq", mem_req, 0);
        end
        mem_rvalid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a = $urandom;
            if (i % 2 == 0) a = a & 32'hFFFF_FFFC;
            do_load(a, 5'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 5));
        end

`ifdef LOAD_TIMEOUT_EN
        ld_valid = 1'b1; ld_addr = 32'h0000_4000; ld_rd = 5'd3; ld_funct3 = 3'b010;
        @(posedge clk); #1;
        ld_valid = 1'b0; mem_rvalid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check_eq("to_memreq", mem_req, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_eq("to_err", ld_err, 1);
        check_eq("to_memreq_drop", mem_req, 0);
        check_eq("to_we", WE3, 0);
        check_eq("to_ready", ld_ready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("to_err_end", ld_err, 0);
        do_load(32'h0000_4008, 5'd3, 3'b010, 32'h0BAD_F00D, 15);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_writeback_unit.md
Name: load_writeback_unit

Overview:
- Load path between the data-memory port and the register file write port (A3/WD3/WE3).
- Accepts one load request at a time and issues a word-aligned read to data memory with a req/rvalid handshake.
- Extracts, aligns and sign- or zero-extends the requested byte, halfword or word.
- Drives a single-cycle register-file write; holds busy so the core stalls while a load is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, cycles mem_req may stay high without mem_rvalid before timeout (used only with the optional feature).
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock, rising-edge active
- rst  input  1  asynchronous active-low reset (0 = reset)
- ld_valid  input  1  load request valid
- ld_ready  output  1  unit can accept a request (state IDLE)
- ld_addr  input  32  byte address
- ld_rd  input  5  destination register
- ld_funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_req  output  1  memory read request
- mem_addr  output  32  {captured addr[31:2], 2'b00}
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read data, little-endian word
- A3  output  5  register file write address
- WD3  output  32  register file write data
- WE3  output  1  register file write enable
- busy  output  1  load outstanding (state != IDLE)
- ld_err  output  1  one-cycle error pulse

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0 except ld_ready=1. All captured registers cleared. A reset mid-operation drops mem_req immediately and abandons the load with no write.
- States: IDLE, REQ, WB.
- IDLE:
  - Handshake fires when ld_valid && ld_ready: capture addr, rd, funct3.
  - Legal and aligned request -> REQ.
  - Error request -> ld_err=1 for the next cycle only, no memory access, no write, stay IDLE.
  - Error means an illegal funct3 (011, 110, 111), LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
- REQ:
  - mem_req=1; mem_addr stable.
  - mem_rvalid=1 -> latch extracted data, go to WB.
  - mem_rvalid is sampled only in REQ; an rvalid in IDLE or WB is ignored.
- WB (exactly one cycle):
  - WE3=1, A3=rd, WD3=data, then -> IDLE.
  - If rd==0: WE3=0, A3=0, WD3=0; the state still passes through WB.
- Extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - LW passes mem_rdata unchanged.
- Outputs:
  - ld_ready=1 only in IDLE; busy=!ld_ready.
  - A3/WD3/WE3 are all registered; they are 0 outside WB.
- Latency:
  - Accept at edge 0 -> mem_req high in cycle 1.
  - rvalid sampled at edge N -> WE3 high in cycle N+1.
  - Minimum accept-to-write is 3 cycles (rvalid on first REQ cycle).
- Back-to-back: the next request can be accepted in the cycle after WB (IDLE), never during WB.

Optional Feature:
- Macro: LOAD_TIMEOUT_EN.
- Defined:
  - A CNT_W-bit counter clears on entry to REQ and increments each REQ cycle without rvalid.
  - On reaching TIMEOUT_CYCLES, if rvalid is still low: ld_err pulses 1 cycle, mem_req drops, no write, -> IDLE.
  - If rvalid coincides with the terminal count, rvalid wins and the load completes normally.
- Not defined: no counter logic; REQ waits indefinitely for rvalid.

Test Plan:
- LW at 0x2004, rd=9, mem_rdata=0xDEADBEEF, rvalid after 2 REQ cycles -> mem_addr=0x2004; one-cycle WE3=1, A3=9, WD3=0xDEADBEEF; busy high 4 cycles.
- LB and LBU at 0x1003, rd=5, mem_rdata=0x80FF_0000 -> LB WD3=0xFFFFFF80, LBU WD3=0x00000080; LH at 0x1002, same data -> WD3=0xFFFF80FF.
- LH at 0x1001, then funct3=011 at 0x1000 -> each gives ld_err one-cycle pulse, mem_req never asserted, WE3 stays 0, ld_ready stays 1.
- LW with rd=0, rvalid immediate -> mem_req asserted, WE3=0 throughout; next request accepted the cycle after WB.
- rst driven low mid-REQ, async to clk -> mem_req and busy drop immediately; a later rvalid=1 produces no write; after release, ld_ready=1.
- With LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=16, rvalid never asserted -> ld_err pulses after 16 REQ cycles, no write, IDLE. Repeat with rvalid on cycle 16 -> normal write, no ld_err.
